// File: rtl/bbox_scan_ctrl.sv
// Raster-scans two pixel RAMs through a shared read address and compares each returned pixel pair.
// It accumulates the bounding box of the changed pixels and reports it with a start/done handshake.
module bbox_scan_ctrl #(
   parameter int WIDTH   = 100,
   parameter int HEIGHT  = 100,
   parameter int ADDR_W  = 15,
   parameter int COORD_W = 11,
   parameter int RD_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [7:0]         thresh,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [23:0]        bg_rdata,
   input  logic [23:0]        ob_rdata,
   output logic [COORD_W-1:0] x_min,
   output logic [COORD_W-1:0] x_max,
   output logic [COORD_W-1:0] y_min,
   output logic [COORD_W-1:0] y_max
);
   localparam int N  = WIDTH * HEIGHT;
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int DW = $clog2(RD_LAT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
   localparam logic [XW-1:0]     X_LAST     = XW'(WIDTH - 1);
   localparam logic [YW-1:0]     Y_LAST     = YW'(HEIGHT - 1);
   localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t                   state, stateNxt;
   logic [ADDR_W-1:0]        addr;
   logic [XW-1:0]            xCnt;
   logic [YW-1:0]            yCnt;
   logic [DW-1:0]            drainCnt;
   logic [RD_LAT:1]          vldPipe;
   logic [RD_LAT:1][XW-1:0]  xPipe;
   logic [RD_LAT:1][YW-1:0]  yPipe;
   logic [XW-1:0]            xmn, xmx;
   logic [YW-1:0]            ymn, ymx;
   logic                     hit;
   logic                     changed;
   logic                     lastRd;

   function automatic logic [7:0] absDiff(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   always_comb begin
      changed = 1'b0;
      for (int c = 0; c < 3; c++)
         if (absDiff(bg_rdata[8*c +: 8], ob_rdata[8*c +: 8]) > thresh) changed = 1'b1;
   end

   assign lastRd  = (addr == LAST_ADDR);
   assign busy    = (state != IDLE);
   assign rd_en   = (state == SCAN);
   assign done    = (state == DONE);
   assign rd_addr = addr;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= stateNxt;

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (start && !abort) stateNxt = SCAN;
         SCAN:    if (abort) stateNxt = IDLE;
                  else if (lastRd) stateNxt = DRAIN;
         DRAIN:   if (abort) stateNxt = IDLE;
                  else if (drainCnt == DRAIN_LAST) stateNxt = DONE;
         DONE:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         xCnt     <= '0;
         yCnt     <= '0;
         drainCnt <= '0;
         vldPipe  <= '0;
         xPipe    <= '0;
         yPipe    <= '0;
         xmn      <= '0;
         xmx      <= '0;
         ymn      <= '0;
         ymx      <= '0;
         hit      <= 1'b0;
         found    <= 1'b0;
         x_min    <= '0;
         x_max    <= '0;
         y_min    <= '0;
         y_max    <= '0;
      end else begin
         // Counters only advance while staying in SCAN, so they park at 0 otherwise.
         if (state == SCAN && stateNxt == SCAN) begin
            addr <= addr + 1'b1;
            if (xCnt == X_LAST) begin
               xCnt <= '0;
               yCnt <= yCnt + 1'b1;
            end else begin
               xCnt <= xCnt + 1'b1;
            end
         end else begin
            addr <= '0;
            xCnt <= '0;
            yCnt <= '0;
         end

         drainCnt <= (state == DRAIN) ? drainCnt + 1'b1 : '0;

         // Coordinates ride alongside the read so they line up with the returned data.
         vldPipe[1] <= rd_en && !abort;
         xPipe[1]   <= xCnt;
         yPipe[1]   <= yCnt;
         for (int i = 2; i <= RD_LAT; i++) begin
            vldPipe[i] <= vldPipe[i-1] && !abort;
            xPipe[i]   <= xPipe[i-1];
            yPipe[i]   <= yPipe[i-1];
         end

         if (state == IDLE && stateNxt == SCAN) begin
            xmn <= X_LAST;
            xmx <= '0;
            ymn <= Y_LAST;
            ymx <= '0;
            hit <= 1'b0;
         end else if (vldPipe[RD_LAT] && changed) begin
            hit <= 1'b1;
            if (xPipe[RD_LAT] < xmn) xmn <= xPipe[RD_LAT];
            if (xPipe[RD_LAT] > xmx) xmx <= xPipe[RD_LAT];
            if (yPipe[RD_LAT] < ymn) ymn <= yPipe[RD_LAT];
            if (yPipe[RD_LAT] > ymx) ymx <= yPipe[RD_LAT];
         end

         if (state == DRAIN && stateNxt == DONE) begin
            found <= hit;
            x_min <= hit ? COORD_W'(xmn) : '0;
            x_max <= hit ? COORD_W'(xmx) : '0;
            y_min <= hit ? COORD_W'(ymn) : '0;
            y_max <= hit ? COORD_W'(ymx) : '0;
         end
      end
   end
endmodule
